// File: rtl/aes_encrypt.sv
// Iterative AES-256 encryption core: one round per clock, round keys expanded on the fly.
// Optional AES_RESTART_EN lets ready abort a busy block and restart it with the new inputs.
module aes_encrypt (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ready,
  input  logic [127:0] data_in,
  input  logic [255:0] key,
  output logic [127:0] data_out,
  output logic         valid
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRound = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  localparam logic [2047:0] SboxTable = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry 0 sits in the top byte, so entry b starts at bit 8*(255-b)+7 = {~b, 3'b111}.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SboxTable[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  logic [1:0]   fsm_q;
  logic [3:0]   round_q;
  logic [127:0] state_q;
  logic [255:0] kwin_q;

  logic [127:0] sub_st, shift_st, mix_st, round_out;
  logic [31:0]  sub_w, key_t, n0, n1, n2, n3;
  logic [7:0]   rcon;
  logic [255:0] kwin_d;
  logic         start;

  always_comb begin
    sub_st   = '0;
    shift_st = '0;
    mix_st   = '0;
    for (int i = 0; i < 16; i++) begin
      sub_st[127-8*i -: 8] = sbox(state_q[127-8*i -: 8]);
    end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shift_st[127-8*(4*c+r) -: 8] = sub_st[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mix_st[127-32*c -: 32] = mix_column(shift_st[127-32*c -: 32]);
    end
    round_out = ((round_q == 4'd14) ? shift_st : mix_st) ^ kwin_q[127:0];

    // SubWord commutes with RotWord, so rotation is applied after substitution.
    sub_w  = {sbox(kwin_q[31:24]), sbox(kwin_q[23:16]), sbox(kwin_q[15:8]), sbox(kwin_q[7:0])};
    rcon   = 8'h01 << round_q[3:1];
    key_t  = round_q[0] ? ({sub_w[23:0], sub_w[31:24]} ^ {rcon, 24'h0}) : sub_w;
    n0     = kwin_q[255:224] ^ key_t;
    n1     = kwin_q[223:192] ^ n0;
    n2     = kwin_q[191:160] ^ n1;
    n3     = kwin_q[159:128] ^ n2;
    kwin_d = {kwin_q[127:0], n0, n1, n2, n3};

`ifdef AES_RESTART_EN
    start = ready;
`else
    start = ready && (fsm_q == StIdle);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      fsm_q    <= StIdle;
      round_q  <= 4'd0;
      state_q  <= '0;
      kwin_q   <= '0;
      data_out <= '0;
      valid    <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (fsm_q == StDone) begin
        data_out <= state_q;
        valid    <= 1'b1;
      end
      if (start) begin
        state_q <= data_in ^ key[255:128];
        kwin_q  <= key;
        round_q <= 4'd1;
        fsm_q   <= StRound;
      end else begin
        case (fsm_q)
          StRound: begin
            state_q <= round_out;
            kwin_q  <= kwin_d;
            if (round_q == 4'd14) begin
              round_q <= 4'd0;
              fsm_q   <= StDone;
            end else begin
              round_q <= round_q + 4'd1;
            end
          end
          StDone:  fsm_q <= StIdle;
          default: fsm_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aes_encrypt.sv
// Self-checking bench for aes_encrypt against a byte-level AES-256 reference model.
module tb_aes_encrypt;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ready;
  logic [127:0] data_in;
  logic [255:0] key;
  logic [127:0] data_out;
  logic         valid;

  int total = 0;
  int bad   = 0;

  logic [7:0] sbox_t [256];

  aes_encrypt dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ready    (ready),
    .data_in  (data_in),
    .key      (key),
    .data_out (data_out),
    .valid    (valid)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box derived from the GF(2^8) inverse and the affine map, not from a table.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  function automatic logic [127:0] aes256_ref(input logic [127:0] pt, input logic [255:0] k);
    logic [31:0]  w [60];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [127:0] res;
    for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      tmp = w[i-1];
      if (i % 8 == 0) begin
        tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end else if (i % 8 == 4) begin
        tmp = sub_word(tmp);
      end
      w[i] = w[i-8] ^ tmp;
    end
    for (int i = 0; i < 16; i++) begin
      tmp  = w[i/4];
      s[i] = pt[127-8*i -: 8] ^ tmp[31-8*(i%4) -: 8];
    end
    for (int r = 1; r <= 14; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) s[4*c+row] = t[4*((c+row)%4)+row];
      if (r < 14) begin
        for (int c = 0; c < 4; c++) begin
          for (int row = 0; row < 4; row++) begin
            t[row] = gmul(8'h02, s[4*c+row]) ^ gmul(8'h03, s[4*c+(row+1)%4]) ^
                     s[4*c+(row+2)%4] ^ s[4*c+(row+3)%4];
          end
          for (int row = 0; row < 4; row++) s[4*c+row] = t[row];
        end
      end
      for (int i = 0; i < 16; i++) begin
        tmp  = w[4*r + i/4];
        s[i] = s[i] ^ tmp[31-8*(i%4) -: 8];
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [255:0] rnd256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Returns with E0 just past; the caller is #1 after that edge.
  task automatic start_block(input logic [127:0] pt, input logic [255:0] k);
    ready = 1'b1;
    data_in = pt;
    key = k;
    @(posedge clk);
    #1;
    ready = 1'b0;
  endtask

  // Cycles from the current point until valid is seen; -1 on timeout.
  task automatic wait_valid(input int budget, input bit scramble, output int cyc);
    bit got = 1'b0;
    cyc = 0;
    while (cyc < budget && !got) begin
      @(posedge clk);
      #1;
      cyc++;
      if (valid) got = 1'b1;
      else if (scramble) begin
        data_in = rnd128();
        key = rnd256();
      end
    end
    if (!got) cyc = -1;
  endtask

  task automatic count_valid(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (valid) n++;
    end
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b1;
    ready = 1'b0;
    data_in = '0;
    key = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (data_out !== 128'h0) begin
      bad++; $display("FAIL reset_data_out got=%h want=0", data_out);
    end
    total++;
    if (valid !== 1'b0) begin
      bad++; $display("FAIL reset_valid got=%b want=0", valid);
    end
    rst_n = 1'b0;
    count_valid(25, n);
    total++;
    if (n !== 0) begin
      bad++; $display("FAIL idle_no_valid got=%0d pulses want=0", n);
    end
  endtask

  task automatic run_known(input string name, input logic [127:0] pt, input logic [255:0] k,
                           input logic [127:0] want);
    int cyc;
    logic [127:0] mdl;
    mdl = aes256_ref(pt, k);
    total++;
    if (mdl !== want) begin
      bad++; $display("FAIL %s_model got=%h want=%h", name, mdl, want);
    end
    start_block(pt, k);
    wait_valid(40, 1'b0, cyc);
    total++;
    if (cyc !== 15) begin
      bad++; $display("FAIL %s_latency got=%0d want=15", name, cyc);
    end
    total++;
    if (data_out !== want) begin
      bad++; $display("FAIL %s_data got=%h want=%h", name, data_out, want);
    end
    @(posedge clk);
    #1;
    total++;
    if (valid !== 1'b0) begin
      bad++; $display("FAIL %s_pulse_width got=%b want=0", name, valid);
    end
  endtask

  task automatic test_known_answers();
    int cyc;
    logic [127:0] want;
    run_known("fips_c3", 128'h00112233445566778899aabbccddeeff,
              256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
              128'h8ea2b7ca516745bfeafc49904b496089);
    run_known("zero", 128'h0, 256'h0, 128'hdc95c078a2408989ad48a21492842087);
    want = aes256_ref(128'h0, 256'd1);
    start_block(128'h0, 256'd1);
    wait_valid(40, 1'b0, cyc);
    total++;
    if (cyc !== 15 || data_out !== want) begin
      bad++; $display("FAIL key_one got=%h cyc=%0d want=%h cyc=15", data_out, cyc, want);
    end
  endtask

  task automatic test_input_change();
    int cyc;
    logic [127:0] pt, want;
    logic [255:0] k;
    for (int t = 0; t < 3; t++) begin
      pt = rnd128();
      k = rnd256();
      want = aes256_ref(pt, k);
      start_block(pt, k);
      data_in = rnd128();
      key = rnd256();
      wait_valid(40, 1'b1, cyc);
      total++;
      if (cyc !== 15 || data_out !== want) begin
        bad++; $display("FAIL input_change got=%h cyc=%0d want=%h cyc=15", data_out, cyc, want);
      end
      repeat (5) begin
        @(posedge clk);
        #1;
        data_in = rnd128();
        key = rnd256();
      end
      total++;
      if (valid !== 1'b0 || data_out !== want) begin
        bad++; $display("FAIL hold_after got=%h v=%b want=%h v=0", data_out, valid, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [127:0] pt, want;
    logic [255:0] k;
    pt = rnd128();
    k = rnd256();
    start_block(pt, k);
    wait_valid(40, 1'b0, cyc);
    for (int t = 0; t < 3; t++) begin
      // Ready raised in the DONE->IDLE cycle is taken at the very next edge.
      pt = rnd128();
      k = rnd256();
      want = aes256_ref(pt, k);
      start_block(pt, k);
      wait_valid(40, 1'b0, cyc);
      total++;
      if (cyc !== 15 || data_out !== want) begin
        bad++; $display("FAIL back_to_back got=%h cyc=%0d want=%h cyc=15", data_out, cyc, want);
      end
    end
  endtask

  task automatic test_busy_ready();
    int cyc, n, want_cyc;
    logic [127:0] pa, pb, want;
    logic [255:0] ka, kb;
    pa = rnd128(); ka = rnd256();
    pb = rnd128(); kb = rnd256();
    start_block(pa, ka);
    repeat (4) @(posedge clk);
    #1;
    start_block(pb, kb);
`ifdef AES_RESTART_EN
    want_cyc = 15;
    want = aes256_ref(pb, kb);
`else
    want_cyc = 10;
    want = aes256_ref(pa, ka);
`endif
    wait_valid(40, 1'b0, cyc);
    total++;
    if (cyc !== want_cyc || data_out !== want) begin
      bad++;
      $display("FAIL busy_ready got=%h cyc=%0d want=%h cyc=%0d", data_out, cyc, want, want_cyc);
    end
    count_valid(25, n);
    total++;
    if (n !== 0) begin
      bad++; $display("FAIL busy_extra_valid got=%0d pulses want=0", n);
    end
  endtask

  task automatic test_mid_reset();
    int cyc, n;
    logic [127:0] pt, want;
    logic [255:0] k;
    start_block(rnd128(), rnd256());
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    total++;
    if (valid !== 1'b0 || data_out !== 128'h0) begin
      bad++; $display("FAIL mid_reset_clear got=%h v=%b want=0 v=0", data_out, valid);
    end
    count_valid(25, n);
    total++;
    if (n !== 0) begin
      bad++; $display("FAIL mid_reset_no_valid got=%0d pulses want=0", n);
    end
    // Reset and ready together: reset must win.
    rst_n = 1'b1;
    start_block(rnd128(), rnd256());
    rst_n = 1'b0;
    count_valid(25, n);
    total++;
    if (n !== 0) begin
      bad++; $display("FAIL reset_wins got=%0d pulses want=0", n);
    end
    pt = rnd128();
    k = rnd256();
    want = aes256_ref(pt, k);
    start_block(pt, k);
    wait_valid(40, 1'b0, cyc);
    total++;
    if (cyc !== 15 || data_out !== want) begin
      bad++; $display("FAIL after_reset got=%h cyc=%0d want=%h cyc=15", data_out, cyc, want);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    ready = 1'b0;
    data_in = '0;
    key = '0;
    build_sbox();
    test_reset();
    test_known_answers();
    test_input_change();
    test_back_to_back();
    test_busy_ready();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
